hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central hazard and stall controller for the five-stage pipelined RISC-V core. It drives the EX-stage operand forwarding selects and detects load-use hazards. It also generates the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM sequences multi-cycle data-memory accesses: it freezes the pipeline while memory is not ready and raises a sticky error on timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum consecutive memory-stall cycles before entering error; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1d, rs2d  in  5  source registers in D.
- rs1e, rs2e, rde  in  5  sources and destination in E.
- resultsrce0  in  1  instruction in E is a load.
- pcsrce  in  1  branch/jump taken in E.
- rdm, rdw  in  5  destination registers in M and W.
- regwritem, regwritew  in  1  register-write enables in M and W.
- memreqm  in  1  load/store in M requests data memory.
- memreadym  in  1  data memory completes the access this cycle.
- forwardae, forwardbe  out  2  EX operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- stallf, stalld, stalle, stallm  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- flushd, flushe, flushw  out  1  bubble into IF/ID, ID/EX, MEM/WB. flushw forces the W-stage write enable low.
- memerr  out  1  sticky memory timeout flag.
- stallcount  out  32  stall-cycle counter (see Configuration).
- flushcount  out  32  taken-branch flush counter (see Configuration).

## Operation
- Forwarding (combinational), per operand X in {rs1e, rs2e}:
  - 10 if regwritem and rdm!=0 and rdm==X.
  - Else 01 if regwritew and rdw!=0 and rdw==X.
  - Else 00.
  - The M stage wins when M and W both match.
- Load-use: lwstall = resultsrce0 and rde!=0 and (rde==rs1d or rde==rs2d).
- Memory stall: memstall = (state!=ERR and memreqm and !memreadym) or state==ERR.
- Output equations:
  - stallf = stalld = memstall or lwstall.
  - stalle = stallm = memstall.
  - flushd = pcsrce and !memstall.
  - flushe = (lwstall or pcsrce) and !memstall.
  - flushw = memstall.
- Priority: memstall dominates. Under memstall no D/E flush is issued; the branch/load held in E is re-evaluated on the release cycle.
- FSM states RUN, WAIT, ERR. waitcnt is $clog2(MEM_TIMEOUT+1) bits.
  - RUN: if memreqm and !memreadym, go to WAIT with waitcnt=1; otherwise stay, waitcnt=0.
  - WAIT, memreadym=1: go to RUN, waitcnt=0. Stall is already deasserted this cycle.
  - WAIT, still not ready: waitcnt+1. If MEM_TIMEOUT!=0 and waitcnt==MEM_TIMEOUT-1, go to ERR and set memerr.
  - WAIT, memreqm=0: abandoned request, go to RUN.
  - ERR: absorbing. Whole pipeline stalled, memerr=1 until reset.
- Reset mid-wait: state RUN, waitcnt 0, memerr 0 immediately (asynchronous).

## Timing
- Forwarding, stall and flush outputs are combinational from current inputs plus state; there is no added latency.
- A single stall cycle occurs for a load-use hazard.
- A memory access with N not-ready cycles stalls exactly N cycles. The pipeline advances in the cycle memreadym=1.
- ERR entry: memerr rises at the edge ending the MEM_TIMEOUT-th consecutive stalled cycle.
- Reset values:
  - forwardae=forwardbe=00.
  - All stall and flush outputs 0 when inputs are idle.
  - memerr=0, stallcount=0, flushcount=0, state=RUN.
- memreadym with memreqm=0 is ignored.

## Configuration
- HAZARD_PERF_EN defined:
  - stallcount increments on each cycle stallf=1.
  - flushcount increments on each cycle flushd=1.
  - Both wrap from 0xFFFFFFFF to 0 and are cleared by reset.
- Undefined: both outputs tied to 0 and no counter flops are built. Ports remain present.

## Test plan
- Forwarding: rs1e=5, rdm=5, regwritem=1, rdw=5, regwritew=1 -> forwardae=10. Drop regwritem -> 01. rdm=rdw=0 -> 00.
- Load-use: resultsrce0=1, rde=7, rs2d=7 -> stallf=stalld=flushe=1, stalle=0 for one cycle. rde=0 -> no stall.
- Branch: pcsrce=1, no memory stall -> flushd=flushe=1. Same with memreqm=1, memreadym=0 -> flushes 0, stallf..stallm=1, flushw=1.
- Memory wait: memreqm=1 with memreadym low 3 cycles then high -> memstall 3 cycles, state RUN after. With HAZARD_PERF_EN, stallcount=3.
- Timeout: MEM_TIMEOUT=4, memreadym held 0 -> memerr=1 after 4th stalled cycle, stays 1 when memreadym later rises. Reset clears it asynchronously.
- Reset mid-WAIT: assert reset between edges -> all outputs return to reset values without waiting for clk.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the five-stage RISC-V pipeline.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1d,
    input  logic [4:0]  rs2d,
    input  logic [4:0]  rs1e,
    input  logic [4:0]  rs2e,
    input  logic [4:0]  rde,
    input  logic        resultsrce0,
    input  logic        pcsrce,
    input  logic [4:0]  rdm,
    input  logic [4:0]  rdw,
    input  logic        regwritem,
    input  logic        regwritew,
    input  logic        memreqm,
    input  logic        memreadym,
    output logic [1:0]  forwardae,
    output logic [1:0]  forwardbe,
    output logic        stallf,
    output logic        stalld,
    output logic        stalle,
    output logic        stallm,
    output logic        flushd,
    output logic        flushe,
    output logic        flushw,
    output logic        memerr,
    output logic [31:0] stallcount,
    output logic [31:0] flushcount
);

    localparam int unsigned WCW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WCW-1:0] LAST_WAIT = WCW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] waitcnt_q, waitcnt_d;
    logic           memerr_q, memerr_d;

    logic lwstall;
    logic mem_pending;
    logic memstall;

    always_comb begin
        forwardae = 2'b00;
        if (regwritem && (rdm != 5'd0) && (rdm == rs1e)) begin
            forwardae = 2'b10;
        end else if (regwritew && (rdw != 5'd0) && (rdw == rs1e)) begin
            forwardae = 2'b01;
        end

        forwardbe = 2'b00;
        if (regwritem && (rdm != 5'd0) && (rdm == rs2e)) begin
            forwardbe = 2'b10;
        end else if (regwritew && (rdw != 5'd0) && (rdw == rs2e)) begin
            forwardbe = 2'b01;
        end
    end

    always_comb begin
        lwstall     = resultsrce0 && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));
        mem_pending = memreqm && !memreadym;
        memstall    = (state_q == ERR) || mem_pending;

        stallf = memstall || lwstall;
        stalld = memstall || lwstall;
        stalle = memstall;
        stallm = memstall;
        flushd = pcsrce && !memstall;
        flushe = (lwstall || pcsrce) && !memstall;
        flushw = memstall;
    end

    always_comb begin
        state_d   = state_q;
        waitcnt_d = waitcnt_q;
        memerr_d  = memerr_q;
        unique case (state_q)
            RUN: begin
                if (mem_pending) begin
                    // A one-cycle budget expires on the very first stalled cycle.
                    if (TIMEOUT_EN && (MEM_TIMEOUT == 1)) begin
                        state_d  = ERR;
                        memerr_d = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        waitcnt_d = WCW'(1);
                    end
                end else begin
                    waitcnt_d = '0;
                end
            end
            WAIT: begin
                if (!memreqm || memreadym) begin
                    state_d   = RUN;
                    waitcnt_d = '0;
                end else if (TIMEOUT_EN && (waitcnt_q == LAST_WAIT)) begin
                    state_d  = ERR;
                    memerr_d = 1'b1;
                end else begin
                    waitcnt_d = waitcnt_q + WCW'(1);
                end
            end
            ERR: begin
                memerr_d = 1'b1;
            end
            default: begin
                state_d   = RUN;
                waitcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            waitcnt_q <= '0;
            memerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitcnt_q <= waitcnt_d;
            memerr_q  <= memerr_d;
        end
    end

    assign memerr = memerr_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallcount_q, stallcount_d;
    logic [31:0] flushcount_q, flushcount_d;

    always_comb begin
        stallcount_d = stallcount_q + {31'd0, stallf};
        flushcount_d = flushcount_q + {31'd0, flushd};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcount_q <= '0;
            flushcount_q <= '0;
        end else begin
            stallcount_q <= stallcount_d;
            flushcount_q <= flushcount_d;
        end
    end

    assign stallcount = stallcount_q;
    assign flushcount = flushcount_q;
`else
    assign stallcount = '0;
    assign flushcount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, corner sequences, and
// randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int TO = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        resultsrce0, pcsrce, regwritem, regwritew, memreqm, memreadym;
    logic [1:0]  forwardae, forwardbe;
    logic        stallf, stalld, stalle, stallm, flushd, flushe, flushw, memerr;
    logic [31:0] stallcount, flushcount;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .resultsrce0(resultsrce0), .pcsrce(pcsrce),
        .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
        .memreqm(memreqm), .memreadym(memreadym),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
        .flushd(flushd), .flushe(flushe), .flushw(flushw), .memerr(memerr),
        .stallcount(stallcount), .flushcount(flushcount)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic ld, pc, rwm, rww, mreq, mrdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [1:0] fa, fb;
        logic       sf, se, fd, fe, fw;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: count of consecutive stalled memory cycles and a sticky error.
    int          m_run;
    bit          m_err;
    logic [31:0] m_sc, m_fc;
    in_t         cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] r1d, r2d, r1e, r2e, rd_e, rd_m, rd_w,
                               input logic ld, pc, rwm, rww, mreq, mrdy);
        in_t t;
        t.rs1d = r1d; t.rs2d = r2d; t.rs1e = r1e; t.rs2e = r2e;
        t.rde = rd_e; t.rdm = rd_m; t.rdw = rd_w;
        t.ld = ld; t.pc = pc; t.rwm = rwm; t.rww = rww; t.mreq = mreq; t.mrdy = mrdy;
        return t;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] x, input in_t i);
        if (i.rwm && i.rdm != 0 && i.rdm == x) return 2'b10;
        if (i.rww && i.rdw != 0 && i.rdw == x) return 2'b01;
        return 2'b00;
    endfunction

    function automatic vec_t model_out(input in_t i);
        vec_t v;
        logic ms, lw;
        ms   = m_err || (i.mreq && !i.mrdy);
        lw   = i.ld && i.rde != 0 && (i.rde == i.rs1d || i.rde == i.rs2d);
        v.i  = i;
        v.fa = fwd_sel(i.rs1e, i);
        v.fb = fwd_sel(i.rs2e, i);
        v.sf = ms || lw;
        v.se = ms;
        v.fd = i.pc && !ms;
        v.fe = (lw || i.pc) && !ms;
        v.fw = ms;
        return v;
    endfunction

    task automatic drive(input in_t i);
        rs1d = i.rs1d; rs2d = i.rs2d; rs1e = i.rs1e; rs2e = i.rs2e;
        rde = i.rde; rdm = i.rdm; rdw = i.rdw;
        resultsrce0 = i.ld; pcsrce = i.pc; regwritem = i.rwm; regwritew = i.rww;
        memreqm = i.mreq; memreadym = i.mrdy;
        cur = i;
    endtask

    task automatic apply(input in_t i);
        @(negedge clk);
        drive(i);
        #1;
    endtask

    task automatic cmp_vec(input string tag, input vec_t e);
        chk({tag, ".forwardae"}, 32'(forwardae), 32'(e.fa));
        chk({tag, ".forwardbe"}, 32'(forwardbe), 32'(e.fb));
        chk({tag, ".stallf"}, 32'(stallf), 32'(e.sf));
        chk({tag, ".stalld"}, 32'(stalld), 32'(e.sf));
        chk({tag, ".stalle"}, 32'(stalle), 32'(e.se));
        chk({tag, ".stallm"}, 32'(stallm), 32'(e.se));
        chk({tag, ".flushd"}, 32'(flushd), 32'(e.fd));
        chk({tag, ".flushe"}, 32'(flushe), 32'(e.fe));
        chk({tag, ".flushw"}, 32'(flushw), 32'(e.fw));
    endtask

    task automatic check_model(input string tag);
        cmp_vec(tag, model_out(cur));
        chk({tag, ".memerr"}, 32'(memerr), 32'(m_err));
        chk({tag, ".stallcount"}, stallcount, m_sc);
        chk({tag, ".flushcount"}, flushcount, m_fc);
    endtask

    task automatic edge_step();
        vec_t e;
        @(posedge clk);
        e = model_out(cur);
        if (PERF) begin
            m_sc = m_sc + 32'(e.sf);
            m_fc = m_fc + 32'(e.fd);
        end
        if (!m_err) begin
            if (cur.mreq && !cur.mrdy) begin
                m_run++;
                if (TO != 0 && m_run >= TO) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
    endtask

    // Reset asserted between clock edges; outputs are checked before any edge occurs.
    task automatic do_reset(input string tag, input in_t after);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk({tag, ".memerr_async"}, 32'(memerr), 32'd0);
        check_model(tag);
        @(negedge clk);
        reset = 1'b0;
        drive(after);
        edge_step();
    endtask

    in_t  idle;
    in_t  stall_in;
    vec_t tab[13];

    initial begin
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        //                 rs1d rs2d rs1e rs2e rde rdm rdw ld pc rwm rww mreq mrdy
        tab[0].i  = mk(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 0, 0); tab[0].fa  = 2'b10; tab[0].fb  = 2'b00;
        tab[1].i  = mk(0, 0, 5, 0, 0, 5, 5, 0, 0, 0, 1, 0, 0); tab[1].fa  = 2'b01; tab[1].fb  = 2'b00;
        tab[2].i  = mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tab[2].fa  = 2'b00; tab[2].fb  = 2'b00;
        tab[3].i  = mk(0, 0, 9, 9, 0, 9, 9, 0, 0, 0, 1, 0, 0); tab[3].fa  = 2'b01; tab[3].fb  = 2'b01;
        tab[4].i  = mk(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0); tab[4].fa  = 2'b00; tab[4].fb  = 2'b00;
        tab[5].i  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); tab[5].fa  = 2'b00; tab[5].fb  = 2'b00;
        tab[6].i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); tab[6].fa  = 2'b00; tab[6].fb  = 2'b00;
        tab[7].i  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); tab[7].fa  = 2'b00; tab[7].fb  = 2'b00;
        tab[8].i  = idle;                                     tab[8].fa  = 2'b00; tab[8].fb  = 2'b00;
        tab[9].i  = mk(3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 1); tab[9].fa  = 2'b00; tab[9].fb  = 2'b00;
        tab[10].i = mk(0, 0, 3, 3, 0, 3, 3, 0, 0, 1, 1, 0, 0); tab[10].fa = 2'b10; tab[10].fb = 2'b10;
        tab[11].i = mk(4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 0); tab[11].fa = 2'b00; tab[11].fb = 2'b00;
        tab[12].i = idle;                                     tab[12].fa = 2'b00; tab[12].fb = 2'b00;
        //            sf se fd fe fw
        {tab[0].sf,  tab[0].se,  tab[0].fd,  tab[0].fe,  tab[0].fw}  = 5'b00000;
        {tab[1].sf,  tab[1].se,  tab[1].fd,  tab[1].fe,  tab[1].fw}  = 5'b00000;
        {tab[2].sf,  tab[2].se,  tab[2].fd,  tab[2].fe,  tab[2].fw}  = 5'b00000;
        {tab[3].sf,  tab[3].se,  tab[3].fd,  tab[3].fe,  tab[3].fw}  = 5'b00000;
        {tab[4].sf,  tab[4].se,  tab[4].fd,  tab[4].fe,  tab[4].fw}  = 5'b10010;
        {tab[5].sf,  tab[5].se,  tab[5].fd,  tab[5].fe,  tab[5].fw}  = 5'b00000;
        {tab[6].sf,  tab[6].se,  tab[6].fd,  tab[6].fe,  tab[6].fw}  = 5'b00110;
        {tab[7].sf,  tab[7].se,  tab[7].fd,  tab[7].fe,  tab[7].fw}  = 5'b11001;
        {tab[8].sf,  tab[8].se,  tab[8].fd,  tab[8].fe,  tab[8].fw}  = 5'b00000;
        {tab[9].sf,  tab[9].se,  tab[9].fd,  tab[9].fe,  tab[9].fw}  = 5'b10010;
        {tab[10].sf, tab[10].se, tab[10].fd, tab[10].fe, tab[10].fw} = 5'b00000;
        {tab[11].sf, tab[11].se, tab[11].fd, tab[11].fe, tab[11].fw} = 5'b11001;
        {tab[12].sf, tab[12].se, tab[12].fd, tab[12].fe, tab[12].fw} = 5'b00000;

        reset = 1'b1;
        drive(idle);
        model_clear();
        #12;
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;
        edge_step();

        for (int k = 0; k < 13; k++) begin
            apply(tab[k].i);
            cmp_vec($sformatf("tab%0d", k), tab[k]);
            edge_step();
        end

        // Three not-ready cycles, then the access completes.
        do_reset("pre_wait", idle);
        for (int k = 0; k < 3; k++) begin
            apply(stall_in);
            chk($sformatf("wait%0d.stallf", k), 32'(stallf), 32'd1);
            chk($sformatf("wait%0d.stalle", k), 32'(stalle), 32'd1);
            edge_step();
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        chk("wait_done.stallf", 32'(stallf), 32'd0);
        chk("wait_done.stalle", 32'(stalle), 32'd0);
        edge_step();
        apply(idle);
        chk("wait.stallcount", stallcount, PERF ? 32'd3 : 32'd0);
        chk("wait.memerr", 32'(memerr), 32'd0);
        check_model("wait_after");
        edge_step();

        // Timeout into the sticky error state.
        for (int k = 0; k < TO; k++) begin
            apply(stall_in);
            chk($sformatf("to%0d.memerr", k), 32'(memerr), 32'd0);
            chk($sformatf("to%0d.stallf", k), 32'(stallf), 32'd1);
            edge_step();
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        chk("err.memerr", 32'(memerr), 32'd1);
        chk("err.stallf", 32'(stallf), 32'd1);
        chk("err.flushd", 32'(flushd), 32'd0);
        check_model("err");
        edge_step();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        chk("err_hold.memerr", 32'(memerr), 32'd1);
        chk("err_hold.stalle", 32'(stalle), 32'd1);
        edge_step();
        do_reset("err_reset", stall_in);

        // Reset mid-wait must also clear the wait counter.
        apply(stall_in);
        check_model("midwait0");
        edge_step();
        apply(stall_in);
        check_model("midwait1");
        edge_step();
        do_reset("midwait_reset", stall_in);
        for (int k = 1; k < TO; k++) begin
            apply(stall_in);
            chk($sformatf("midwait_cnt%0d.memerr", k), 32'(memerr), 32'd0);
            edge_step();
        end
        apply(stall_in);
        chk("midwait_final.memerr", 32'(memerr), 32'd1);
        edge_step();
        do_reset("post_midwait", idle);

        for (int n = 0; n < 500; n++) begin
            in_t r;
            r.rs1d = 5'($urandom_range(0, 3)); r.rs2d = 5'($urandom_range(0, 3));
            r.rs1e = 5'($urandom_range(0, 3)); r.rs2e = 5'($urandom_range(0, 3));
            r.rde  = 5'($urandom_range(0, 3)); r.rdm  = 5'($urandom_range(0, 3));
            r.rdw  = 5'($urandom_range(0, 3));
            r.ld   = ($urandom_range(0, 2) == 0);
            r.pc   = ($urandom_range(0, 3) == 0);
            r.rwm  = $urandom_range(0, 1) != 0;
            r.rww  = $urandom_range(0, 1) != 0;
            r.mreq = ($urandom_range(0, 3) != 0);
            r.mrdy = ($urandom_range(0, 3) == 0);
            if (m_err && $urandom_range(0, 7) == 0) begin
                do_reset($sformatf("rnd_rst%0d", n), r);
            end else begin
                apply(r);
                check_model($sformatf("rnd%0d", n));
                edge_step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
